// File: rtl/axi_pkg.sv
// Shared AXI write-master types and constants.
// Wrap burst support is controlled by the AXI_WR_WRAP_EN macro in axi_wr_master.
package axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [2:0] Size1B = 3'd0;
  localparam logic [2:0] Size2B = 3'd1;
  localparam logic [2:0] Size4B = 3'd2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StAddr = 3'd1;
  localparam state_t StData = 3'd2;
  localparam state_t StResp = 3'd3;
  localparam state_t StRej  = 3'd4;

endpackage

// File: rtl/axi_strb_gen.sv
// Byte-lane strobe generation for a 32-bit data bus from beat address and size.
module axi_strb_gen
  import axi_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] size,
  output logic [3:0] strb
);

  always_comb begin
    strb = 4'h0;
    case (size)
      Size1B:  strb = 4'b0001 << addr;
      Size2B:  strb = addr[1] ? 4'b1100 : 4'b0011;
      // Lanes below an unaligned start address stay disabled.
      Size4B:  strb = 4'hF << addr;
      default: strb = 4'h0;
    endcase
  end

endmodule

// File: rtl/axi_wr_master.sv
// Single-burst AXI3-style write master: command in, AW/W/B sequencing, done pulse out.
// Define AXI_WR_WRAP_EN to support WRAP bursts; otherwise WRAP commands are rejected.
module axi_wr_master
  import axi_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [31:0]       wd_data,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [ID_W-1:0]   wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              id_err
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q, beat_addr_q, next_addr;
  logic [3:0]          len_q, beat_cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                done_q, id_err_q;
  logic [1:0]          done_resp_q;
  logic                cmd_legal, accept, w_hs, b_hs;

  always_comb begin
    cmd_legal = 1'b1;
    if (cmd_size > Size4B || cmd_burst == 2'b11) cmd_legal = 1'b0;
`ifdef AXI_WR_WRAP_EN
    if (cmd_burst == BurstWrap) begin
      if (!(cmd_len inside {4'd1, 4'd3, 4'd7, 4'd15})) cmd_legal = 1'b0;
      if (cmd_size == Size2B && cmd_addr[0]) cmd_legal = 1'b0;
      if (cmd_size == Size4B && cmd_addr[1:0] != 2'b00) cmd_legal = 1'b0;
    end
`else
    if (cmd_burst == BurstWrap) cmd_legal = 1'b0;
`endif
  end

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_ready && cmd_valid;
  assign awvalid   = (state_q == StAddr);
  assign wvalid    = (state_q == StData) && wd_valid;
  assign wd_ready  = (state_q == StData) && wready;
  assign w_hs      = wvalid && wready;
  assign wlast     = (beat_cnt_q == len_q);
  assign bready    = (state_q == StResp);
  assign b_hs      = bready && bvalid;

  assign awid      = id_q;
  assign awaddr    = addr_q;
  assign awlen     = len_q;
  assign awsize    = size_q;
  assign awburst   = burst_q;
  assign wid       = id_q;
  assign wdata     = wd_data;
  assign done      = done_q;
  assign done_resp = done_resp_q;
  assign id_err    = id_err_q;

  always_comb begin
    logic [ADDR_W-1:0] bytes;
`ifdef AXI_WR_WRAP_EN
    logic [ADDR_W-1:0] wrap_mask;
`endif
    bytes     = ADDR_W'(1) << size_q;
    next_addr = beat_addr_q;
    case (burst_q)
      BurstIncr: next_addr = (beat_addr_q & ~(bytes - ADDR_W'(1))) + bytes;
`ifdef AXI_WR_WRAP_EN
      BurstWrap: begin
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        next_addr = (beat_addr_q & ~wrap_mask) | ((beat_addr_q + bytes) & wrap_mask);
      end
`endif
      default:   next_addr = beat_addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cmd_valid) state_d = cmd_legal ? StAddr : StRej;
      StAddr:  if (awready) state_d = StData;
      StData:  if (w_hs && wlast) state_d = StResp;
      StResp:  if (bvalid) state_d = StIdle;
      StRej:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      id_q        <= '0;
      addr_q      <= '0;
      beat_addr_q <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      done_q      <= 1'b0;
      id_err_q    <= 1'b0;
      done_resp_q <= RespOkay;
    end else begin
      state_q  <= state_d;
      done_q   <= 1'b0;
      id_err_q <= 1'b0;
      if (accept) begin
        id_q        <= cmd_id;
        addr_q      <= cmd_addr;
        beat_addr_q <= cmd_addr;
        len_q       <= cmd_len;
        size_q      <= cmd_size;
        burst_q     <= cmd_burst;
        beat_cnt_q  <= '0;
        if (!cmd_legal) begin
          done_q      <= 1'b1;
          done_resp_q <= RespSlverr;
        end
      end
      if (w_hs) begin
        beat_cnt_q  <= beat_cnt_q + 4'd1;
        beat_addr_q <= next_addr;
      end
      if (b_hs) begin
        done_q <= 1'b1;
        if (bid != id_q) begin
          done_resp_q <= RespSlverr;
          id_err_q    <= 1'b1;
        end else begin
          done_resp_q <= bresp;
        end
      end
    end
  end

  axi_strb_gen u_strb_gen (
    .addr (beat_addr_q[1:0]),
    .size (size_q),
    .strb (wstrb)
  );

endmodule

// File: tb/tb_axi_wr_master.sv
// Self-checking bench for axi_wr_master: directed table, reset-in-burst sequence, random commands.
module tb_axi_wr_master;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              cmd_valid, cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic              wd_valid, wd_ready;
  logic [31:0]       wd_data;
  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready;
  logic [ID_W-1:0]   wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              bvalid;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bready;
  logic              done;
  logic [1:0]        done_resp;
  logic              id_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_wr_master #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
    .done(done), .done_resp(done_resp), .id_err(id_err)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    int          mode;     // 0 random handshakes, 1 always ready, 2 toggling wready
    logic        exp_rej;
    logic [1:0]  exp_resp;
    logic        exp_iderr;
    logic [3:0]  exp_strb0;
    int          exp_beats;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cmd_valid = 0; wd_valid = 0; awready = 0; wready = 0; bvalid = 0;
    step(); step();
    resetn = 1'b1;
    step();
  endtask

  // Reference rules written directly from the burst definitions.
  function automatic logic model_legal(input vec_t c);
    if (c.size > 3'd2 || c.burst == 2'b11) return 1'b0;
    if (c.burst == 2'b10) begin
`ifdef AXI_WR_WRAP_EN
      if (!(c.len == 4'd1 || c.len == 4'd3 || c.len == 4'd7 || c.len == 4'd15)) return 1'b0;
      if ((c.addr % (32'd1 << c.size)) != 0) return 1'b0;
`else
      return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_addr(input vec_t c, input int n);
    logic [31:0] bytes, win, lo;
    bytes = 32'd1 << c.size;
    case (c.burst)
      2'b01:   return (n == 0) ? c.addr : (c.addr - (c.addr % bytes)) + 32'(n) * bytes;
      2'b10: begin
        win = (32'(c.len) + 32'd1) * bytes;
        lo  = c.addr - (c.addr % win);
        return lo + ((c.addr - lo + 32'(n) * bytes) % win);
      end
      default: return c.addr;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] size);
    logic [3:0] s;
    int lane0;
    s = 4'h0;
    lane0 = int'(a % 4);
    for (int b = 0; b < 4; b++) begin
      case (size)
        3'd0: s[b] = (b == lane0);
        3'd1: s[b] = ((b / 2) == (lane0 / 2));
        3'd2: s[b] = (b >= lane0);
        default: s[b] = 1'b0;
      endcase
    end
    return s;
  endfunction

  function automatic logic [1:0] model_resp(input vec_t c);
    return (c.bid != c.id) ? 2'b10 : c.bresp;
  endfunction

  task automatic run_cmd(input vec_t c, output logic rej, output logic [1:0] resp,
                         output logic iderr, output logic [3:0] strb0, output int beats);
    logic legal, hs;
    int n, cyc, d;
    legal = model_legal(c);
    iderr = 1'b0; strb0 = 4'h0; beats = 0;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_id = c.id; cmd_addr = c.addr; cmd_len = c.len;
    cmd_size = c.size; cmd_burst = c.burst;
    step();
    cmd_valid = 1'b0;
    rej = done; resp = done_resp;
    if (!legal) begin
      iderr = id_err;
      check("rej_awvalid", awvalid, 1'b0);
      check("rej_wvalid", wvalid, 1'b0);
      check("rej_cmd_ready", cmd_ready, 1'b0);
      step();
      check("rej_done_clear", done, 1'b0);
      check("rej_back_idle", cmd_ready, 1'b1);
      return;
    end
    check("aw_after_accept", awvalid, 1'b1);
    hs = 1'b0;
    for (cyc = 0; cyc < 64 && !hs; cyc++) begin
      awready = (c.mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("aw_held", awvalid, 1'b1);
      check("aw_fields", {awid, awaddr, awlen, awsize, awburst},
            {c.id, c.addr, c.len, c.size, c.burst});
      hs = awready;
      step();
    end
    awready = 1'b0;
    if (!hs) begin
      check("aw_timeout", 1'b0, 1'b1);
      return;
    end
    n = 0;
    for (cyc = 0; n <= int'(c.len) && cyc < 400; cyc++) begin
      case (c.mode)
        1: begin wd_valid = 1'b1; wready = 1'b1; end
        2: begin wd_valid = 1'b1; wready = 1'((cyc % 2) == 1); end
        default: begin wd_valid = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
      endcase
      wd_data = $urandom;
      #1;
      check("w_valid_pass", wvalid, wd_valid);
      check("w_ready_pass", wd_ready, wready);
      check("w_data_id", {wid, wdata}, {c.id, wd_data});
      check("w_no_aw_b", {awvalid, bready}, 2'b00);
      if (wd_valid && wready) begin
        check("w_strb", wstrb, model_strb(model_addr(c, n), c.size));
        check("w_last", wlast, 1'(n == int'(c.len)));
        if (n == 0) strb0 = wstrb;
        n++;
      end
      step();
    end
    wd_valid = 1'b0; wready = 1'b0;
    beats = n;
    if (n <= int'(c.len)) begin
      check("w_timeout", 1'b0, 1'b1);
      return;
    end
    check("resp_bready", bready, 1'b1);
    d = (c.mode == 1) ? 0 : $urandom_range(0, 3);
    for (int i = 0; i < d; i++) begin
      check("resp_wait", {bready, done}, 2'b10);
      step();
    end
    bvalid = 1'b1; bid = c.bid; bresp = c.bresp;
    step();
    bvalid = 1'b0;
    resp = done_resp; iderr = id_err;
    check("resp_done", done, 1'b1);
    check("resp_code", done_resp, model_resp(c));
    check("resp_iderr", id_err, 1'(c.bid != c.id));
    check("resp_bready_low", bready, 1'b0);
    step();
    check("resp_pulse_end", {done, id_err, cmd_ready}, 3'b001);
  endtask

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] bid_v, input logic [1:0] bresp_v, input int mode,
                              input logic exp_rej, input logic [1:0] exp_resp,
                              input logic exp_iderr, input logic [3:0] exp_strb0,
                              input int exp_beats);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.bid = bid_v; v.bresp = bresp_v; v.mode = mode;
    v.exp_rej = exp_rej; v.exp_resp = exp_resp; v.exp_iderr = exp_iderr;
    v.exp_strb0 = exp_strb0; v.exp_beats = exp_beats;
    return v;
  endfunction

  initial begin
    vec_t tbl[12];
    vec_t c;
    logic rej, iderr;
    logic [1:0] resp;
    logic [3:0] strb0;
    int beats, bad_before;

    tbl[0]  = mk(4'd1, 32'h10, 4'd3, 3'd2, 2'b01, 4'd1, 2'b00, 1, 1'b0, 2'b00, 1'b0, 4'hF, 4);
`ifdef AXI_WR_WRAP_EN
    tbl[1]  = mk(4'd2, 32'h38, 4'd3, 3'd2, 2'b10, 4'd2, 2'b00, 1, 1'b0, 2'b00, 1'b0, 4'hF, 4);
    tbl[2]  = mk(4'd3, 32'h3A, 4'd3, 3'd0, 2'b10, 4'd3, 2'b00, 0, 1'b0, 2'b00, 1'b0, 4'h4, 4);
`else
    tbl[1]  = mk(4'd2, 32'h38, 4'd3, 3'd2, 2'b10, 4'd2, 2'b00, 1, 1'b1, 2'b10, 1'b0, 4'h0, 0);
    tbl[2]  = mk(4'd3, 32'h3A, 4'd3, 3'd0, 2'b10, 4'd3, 2'b00, 0, 1'b1, 2'b10, 1'b0, 4'h0, 0);
`endif
    tbl[3]  = mk(4'd4, 32'h40, 4'd1, 3'd3, 2'b01, 4'd4, 2'b00, 1, 1'b1, 2'b10, 1'b0, 4'h0, 0);
    tbl[4]  = mk(4'd6, 32'h21, 4'd1, 3'd0, 2'b00, 4'd6, 2'b00, 2, 1'b0, 2'b00, 1'b0, 4'h2, 2);
    tbl[5]  = mk(4'd5, 32'h00, 4'd0, 3'd2, 2'b01, 4'd6, 2'b00, 1, 1'b0, 2'b10, 1'b1, 4'hF, 1);
    tbl[6]  = mk(4'd7, 32'h80, 4'd2, 3'd2, 2'b11, 4'd7, 2'b00, 1, 1'b1, 2'b10, 1'b0, 4'h0, 0);
    tbl[7]  = mk(4'd8, 32'h13, 4'd2, 3'd2, 2'b01, 4'd8, 2'b00, 0, 1'b0, 2'b00, 1'b0, 4'h8, 3);
    tbl[8]  = mk(4'd9, 32'h02, 4'd0, 3'd1, 2'b01, 4'd9, 2'b01, 0, 1'b0, 2'b01, 1'b0, 4'hC, 1);
    tbl[9]  = mk(4'd1, 32'h40, 4'd2, 3'd2, 2'b10, 4'd1, 2'b00, 0, 1'b1, 2'b10, 1'b0, 4'h0, 0);
    tbl[10] = mk(4'd2, 32'h3A, 4'd3, 3'd2, 2'b10, 4'd2, 2'b00, 0, 1'b1, 2'b10, 1'b0, 4'h0, 0);
    tbl[11] = mk(4'd3, 32'hFFFF_FFFE, 4'd3, 3'd0, 2'b01, 4'd3, 2'b11, 0, 1'b0, 2'b11, 1'b0,
                 4'h4, 4);

    resetn = 1'b0;
    cmd_valid = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wd_valid = 0; wd_data = 0; awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    step(); step();
    check("rst_valids", {awvalid, wvalid, bready, wd_ready}, 4'b0000);
    check("rst_done", {done, id_err, done_resp}, 4'b0000);
    resetn = 1'b1;
    step();
    check("rst_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      bad_before = bad;
      run_cmd(tbl[i], rej, resp, iderr, strb0, beats);
      check($sformatf("tbl%0d_rej", i), rej, tbl[i].exp_rej);
      check($sformatf("tbl%0d_resp", i), resp, tbl[i].exp_resp);
      check($sformatf("tbl%0d_iderr", i), iderr, tbl[i].exp_iderr);
      check($sformatf("tbl%0d_beats", i), beats, tbl[i].exp_beats);
      if (!tbl[i].exp_rej) check($sformatf("tbl%0d_strb0", i), strb0, tbl[i].exp_strb0);
      if (bad != bad_before) do_reset();
    end

    // Reset asserted while the third data beat is being presented.
    cmd_valid = 1'b1; cmd_id = 4'd3; cmd_addr = 32'h100; cmd_len = 4'd3;
    cmd_size = 3'd2; cmd_burst = 2'b01;
    step();
    cmd_valid = 1'b0; awready = 1'b1;
    step();
    awready = 1'b0; wd_valid = 1'b1; wready = 1'b1;
    step(); step();
    check("mid_beat2_wvalid", wvalid, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_valids", {awvalid, wvalid, bready, wd_ready}, 4'b0000);
    check("mid_rst_done", {done, id_err, done_resp}, 4'b0000);
    step(); step();
    wd_valid = 1'b0; wready = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_quiet", {done, awvalid, cmd_ready}, 3'b001);
    end
    c = mk(4'd3, 32'h200, 4'd1, 3'd2, 2'b01, 4'd3, 2'b00, 0, 1'b0, 2'b00, 1'b0, 4'hF, 2);
    run_cmd(c, rej, resp, iderr, strb0, beats);
    check("post_rst_cmd", {rej, resp, iderr, 4'(beats)}, {1'b0, 2'b00, 1'b0, 4'd2});

    for (int i = 0; i < 120; i++) begin
      c.id    = 4'($urandom);
      c.addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      c.len   = 4'($urandom);
      c.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      c.burst = 2'($urandom_range(0, 3));
      if (c.burst == 2'b10 && $urandom_range(0, 1) == 1) begin
        c.len  = 4'((2 << $urandom_range(0, 3)) - 1);
        c.addr = c.addr & ~((32'd1 << c.size) - 32'd1);
      end
      c.bid   = ($urandom_range(0, 5) == 0) ? c.id + 4'd1 : c.id;
      c.bresp = 2'($urandom);
      c.mode  = 0;
      bad_before = bad;
      run_cmd(c, rej, resp, iderr, strb0, beats);
      check("rnd_rej", rej, !model_legal(c));
      check("rnd_resp", resp, model_legal(c) ? model_resp(c) : 2'b10);
      check("rnd_beats", beats, model_legal(c) ? int'(c.len) + 1 : 0);
      if (bad != bad_before) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
